pwm_capture: RTL
================

# pwm_capture

Measures an incoming PWM waveform: the period and high time of each full cycle, in clock cycles. It is the receiving end of the `pwm` generator interface and sits beside it in the top level. Typical uses are closing a loopback on `pwm_o` in test builds and reading external PWM sources such as RC receivers or sensor outputs. It reports each completed measurement with a one-cycle `valid` strobe, and flags a stalled line with `timeout`.

## Interface
- `nbits`, default 16: width of the internal counter and of the `period` and `high` outputs; the maximum measurable period is 2^nbits-1 cycles.
- `clk` in 1: system clock, the HFOSC-derived clock.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: measurement enable; when low, the block idles.
- `in` in 1: PWM input; asynchronous to `clk`.
- `period` out nbits: clk cycles between the last two rising edges.
- `high` out nbits: clk cycles from a rising edge to the following falling edge.
- `valid` out 1: one-cycle strobe; `period` and `high` were updated this cycle.
- `timeout` out 1: no edge seen for 2^nbits-1 cycles; held until the next valid measurement.
- `level` out 1: synchronized line level, latched when `timeout` asserts.

## Operation
- Input conditioning:
  - 2-flop synchronizer `s1` → `s2`, followed by a `prev` flop.
  - `rise = s2 & ~prev`; `fall = ~s2 & prev`.
- Counter `cnt` (nbits):
  - loads 1 on the cycle after `rise`;
  - otherwise increments by 1 per clk in the HIGH and LOW states;
  - never wraps.
- States:
  - IDLE: entered on reset or when `en`=0. `cnt` held at 0. Moves to ARM when `en`=1.
  - ARM: waits for `rise`, which discards the partial cycle after reset, enable, or timeout. On `rise`: `cnt`←1, go to HIGH.
  - HIGH: on `fall`, latch `high_tmp`←`cnt` and go to LOW.
  - LOW: on `rise`:
    - `period`←`cnt`, `high`←`high_tmp`;
    - `valid`←1, `timeout`←0;
    - `cnt`←1, go to HIGH.
- Resulting values: an input high for H cycles and low for L cycles yields `high`=H and `period`=H+L.
- Timeout: in ARM, HIGH or LOW, if `cnt` = 2^nbits-1 and no edge arrives this cycle:
  - `timeout`←1, `level`←`s2`;
  - go to ARM;
  - no `valid`; `period`/`high` keep their previous values.
- ARM has its own idle counter, with the same saturation rule and the same timeout behaviour. A line stuck from reset is therefore also flagged.
- `en` falling in any state: go to IDLE at the next edge. Any in-progress measurement is discarded, no `valid` is produced, and outputs hold.
- Edge arriving on the same cycle as counter saturation: the edge wins; a normal transition occurs and no timeout.
- Pulse width: levels shorter than 1 clk may be missed. Such a pulse can then appear as a longer period or a timeout; this is legal.
- Reset: asynchronous. All flops clear immediately: `period`=0, `high`=0, `valid`=0, `timeout`=0, `level`=0, state IDLE.

## Timing
- Detection latency: `rise`/`fall` is true in the cycle following the 2nd clk edge after `in` is first sampled at its new level.
- `valid` latency: high for exactly one cycle, starting at the 3rd clk edge after the sampling edge of the closing rising edge.
  - `period` and `high` change on that same edge and remain stable until the next `valid`.
- Measurement rate: one `valid` per input period, beginning with the second complete rising edge after ARM is entered.
- `timeout` latency: rises exactly 2^nbits-1 cycles after the last counter load, not counting synchronizer delay.

## Test plan
- Steady PWM, nbits=16, high 3 / low 7 cycles → no `valid` on the first rising edge. Thereafter `valid` every 10 cycles with `period`=10 and `high`=3.
- Minimum waveform, high 1 / low 1 → `period`=2, `high`=1, `valid` every 2 cycles.
- nbits=8, input held at 1 after a valid 10-cycle stream → `timeout`=1 and `level`=1 exactly 255 cycles after the last rise. `period` stays 10. A fresh stream clears `timeout` at its first `valid`.
- `en` dropped mid-HIGH for 5 cycles, then restored → no `valid` for the interrupted cycle. The first `valid` follows the second rising edge after restore, and its values are correct.
- `rst` asserted mid-LOW between clock edges → all outputs go to 0 immediately, without waiting for a clk edge. After release, the first `valid` follows the second rising edge.
- Live loopback of `pwm` (`freq`=`PWM_FREQ`, `nbits`=`PWM_RES`) at a 25% duty → `high`/`period` = 0.25 ±1 cycle, and `period` matches the generator's period.

Source files
------------

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures an incoming PWM waveform. For every complete input cycle it reports
// the period (rising edge to rising edge) and the high time (rising edge to
// falling edge), both in clk cycles, with a one-cycle valid strobe. A line with
// no edges for 2^nbits-1 cycles raises timeout and latches the line level.
//
// Ports
//   clk      system clock
//   rst      asynchronous reset, active low
//   en       measurement enable; low forces the block idle
//   in       PWM input, asynchronous to clk
//   period   clk cycles between the last two rising edges
//   high     clk cycles from a rising edge to the following falling edge
//   valid    one-cycle strobe: period/high were updated this cycle
//   timeout  no edge for 2^nbits-1 cycles; cleared by the next valid
//   level    synchronized line level captured when timeout asserts
// -----------------------------------------------------------------------------
module pwm_capture #(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    output logic [nbits-1:0] period,
    output logic [nbits-1:0] high,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [nbits-1:0] CNT_MAX = '1;
    localparam logic [nbits-1:0] CNT_ONE = {{(nbits-1){1'b0}}, 1'b1};

    state_t           state;
    logic             s1;
    logic             s2;
    logic             prev;
    logic [nbits-1:0] cnt;
    logic [nbits-1:0] cnt_inc;
    logic [nbits-1:0] idle_cnt;
    logic [nbits-1:0] high_tmp;
    logic             rise;
    logic             fall;

    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

    // The measurement counter saturates rather than wrapping, so a long high
    // phase still leads to a timeout instead of a bogus short period.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Two-flop synchronizer followed by an edge-detect history flop.
    // NOTE: flops use non-blocking assignments so every stage samples the
    // pre-edge value of the one before it; blocking would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= in;
            s2   <= s1;
            prev <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idle_cnt <= '0;
            high_tmp <= '0;
            period   <= '0;
            high     <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            level    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                // Any partial measurement is dropped; reported values hold.
                state    <= S_IDLE;
                cnt      <= '0;
                idle_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state    <= S_ARM;
                        idle_cnt <= '0;
                    end

                    // Waits for a clean rising edge so the first measurement
                    // never includes a partial cycle.
                    S_ARM: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= S_HIGH;
                        end else if (idle_cnt == CNT_MAX) begin
                            timeout  <= 1'b1;
                            level    <= s2;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + CNT_ONE;
                        end
                    end

                    // cnt keeps running through HIGH and LOW so that at the
                    // closing rise it holds the full period.
                    S_HIGH: begin
                        if (fall) begin
                            high_tmp <= cnt;
                            cnt      <= cnt_inc;
                            state    <= S_LOW;
                        end else if (cnt == CNT_MAX) begin
                            timeout  <= 1'b1;
                            level    <= s2;
                            idle_cnt <= '0;
                            state    <= S_ARM;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    S_LOW: begin
                        if (rise) begin
                            period  <= cnt;
                            high    <= high_tmp;
                            valid   <= 1'b1;
                            timeout <= 1'b0;
                            cnt     <= CNT_ONE;
                            state   <= S_HIGH;
                        end else if (cnt == CNT_MAX) begin
                            timeout  <= 1'b1;
                            level    <= s2;
                            idle_cnt <= '0;
                            state    <= S_ARM;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
